// File: rtl/uram_row_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// Package  : uram_row_arbiter_pkg
// Brief    : Shared types and defaults for the row URAM arbiter.
// Revision : 1.0
// =============================================================================
package uram_row_arbiter_pkg;

    localparam int ROW_NUM_CORES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        OWNED   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// =============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin pick: first request at or after i_ptr.
// Revision : 1.0
// =============================================================================
module rr_priority_picker
    import uram_row_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ROW_NUM_CORES
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_onehot,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);

    localparam int               c_IW = $clog2(NUM_REQ);
    localparam logic [c_IW:0]    c_N  = (c_IW + 1)'(NUM_REQ);

    logic [c_IW:0]   w_sum;
    logic [c_IW-1:0] w_pos;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_sum    = '0;
        w_pos    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Wrap ptr+i back into range without a modulo operator.
            w_sum = {1'b0, i_ptr} + (c_IW + 1)'(i);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_pos = w_sum[c_IW-1:0];
            if (!o_valid && i_req[w_pos]) begin
                o_valid         = 1'b1;
                o_idx           = w_pos;
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uram_row_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : uram_row_arbiter
// Brief    : Round-robin owner of a row's shared URAM port, gated on drain.
// Revision : 1.0
// =============================================================================
module uram_row_arbiter
    import uram_row_arbiter_pkg::*;
#(
    parameter int NUM_CORES    = ROW_NUM_CORES,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CORES-1:0]              i_core_req,
    input  logic [NUM_CORES-1:0]              i_core_locked,
    output logic [NUM_CORES-1:0]              o_core_grant,
    input  logic [NUM_CORES-1:0]              i_core_uram_en,
    input  logic [NUM_CORES-1:0]              i_core_uram_wr_en,
    input  logic [NUM_CORES-1:0][ADDR_W-1:0]  i_core_uram_addr,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]  i_core_uram_wr_data,
    output logic                              o_uram_en,
    output logic                              o_uram_wr_en,
    output logic [ADDR_W-1:0]                 o_uram_addr,
    output logic [DATA_W-1:0]                 o_uram_wr_data,
    input  logic                              i_drain_done,
    output logic                              o_uram_emptied,
    output logic [ADDR_W:0]                   o_wr_count,
    output logic [$clog2(NUM_CORES)-1:0]      o_owner,
    output logic                              o_busy
);

    localparam int               c_OW     = $clog2(NUM_CORES);
    localparam int               c_TW     = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [ADDR_W:0]  c_WR_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [c_OW-1:0]  c_LAST   = c_OW'(NUM_CORES - 1);
    localparam logic [c_TW-1:0]  c_TMO    = c_TW'(LOCK_TIMEOUT);

    arb_state_t             r_state;
    logic [NUM_CORES-1:0]   r_grant;
    logic [NUM_CORES-1:0]   r_owner_onehot;
    logic [c_OW-1:0]        r_owner;
    logic [c_OW-1:0]        r_ptr;
    logic [c_TW-1:0]        r_timer;
    logic                   r_locked_prev;
    logic                   r_emptied;
    logic [ADDR_W:0]        r_wr_count;
    logic                   r_drain_pending;
    logic                   r_uram_en;
    logic                   r_uram_wr_en;
    logic [ADDR_W-1:0]      r_uram_addr;
    logic [DATA_W-1:0]      r_uram_wr_data;

    logic [NUM_CORES-1:0]   w_pick_onehot;
    logic [c_OW-1:0]        w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_owner_locked;
    logic                   w_owner_write;

    rr_priority_picker #(
        .NUM_REQ (NUM_CORES)
    ) u_picker (
        .i_req    (i_core_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_owner_locked = i_core_locked[r_owner];
    assign w_owner_write  = i_core_uram_en[r_owner] & i_core_uram_wr_en[r_owner];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_grant         <= '0;
            r_owner_onehot  <= '0;
            r_owner         <= '0;
            r_ptr           <= '0;
            r_timer         <= '0;
            r_locked_prev   <= 1'b0;
            r_emptied       <= 1'b1;
            r_wr_count      <= '0;
            r_drain_pending <= 1'b0;
            r_uram_en       <= 1'b0;
            r_uram_wr_en    <= 1'b0;
            r_uram_addr     <= '0;
            r_uram_wr_data  <= '0;
        end else begin
            r_locked_prev <= w_owner_locked;
            case (r_state)
                IDLE: begin
                    r_grant <= '0;
                    r_timer <= '0;
                    if (i_drain_done) begin
                        r_emptied       <= 1'b1;
                        r_wr_count      <= '0;
                        r_drain_pending <= 1'b0;
                    end
                    // Uses the pre-drain emptied flag, so a coincident drain delays arbitration by one cycle.
                    if (r_emptied && w_pick_valid) begin
                        r_owner        <= w_pick_idx;
                        r_owner_onehot <= w_pick_onehot;
                        r_state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (i_drain_done) begin
                        r_drain_pending <= 1'b1;
                    end
                    if (w_owner_locked) begin
                        r_grant <= r_owner_onehot;
                        r_state <= OWNED;
                    end else if (r_timer == c_TMO) begin
                        r_grant <= '0;
                        r_state <= RELEASE;
                    end else begin
                        r_grant <= r_owner_onehot;
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                OWNED: begin
                    r_uram_en      <= i_core_uram_en[r_owner];
                    r_uram_wr_en   <= i_core_uram_wr_en[r_owner];
                    r_uram_addr    <= i_core_uram_addr[r_owner];
                    r_uram_wr_data <= i_core_uram_wr_data[r_owner];
                    if (w_owner_write) begin
                        r_emptied <= 1'b0;
                        if (r_wr_count != c_WR_MAX) begin
                            r_wr_count <= r_wr_count + (ADDR_W + 1)'(1);
                        end
                    end
                    if (i_drain_done) begin
                        r_drain_pending <= 1'b1;
                    end
                    if (r_locked_prev && !w_owner_locked) begin
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_grant        <= '0;
                    r_uram_en      <= 1'b0;
                    r_uram_wr_en   <= 1'b0;
                    r_uram_addr    <= '0;
                    r_uram_wr_data <= '0;
                    r_ptr          <= (r_owner == c_LAST) ? '0 : r_owner + c_OW'(1);
                    r_state        <= IDLE;
                    if (r_drain_pending || i_drain_done) begin
                        r_emptied       <= 1'b1;
                        r_wr_count      <= '0;
                        r_drain_pending <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_core_grant   = r_grant;
    assign o_uram_en      = r_uram_en;
    assign o_uram_wr_en   = r_uram_wr_en;
    assign o_uram_addr    = r_uram_addr;
    assign o_uram_wr_data = r_uram_wr_data;
    assign o_uram_emptied = r_emptied;
    assign o_wr_count     = r_wr_count;
    assign o_owner        = r_owner;
    assign o_busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uram_row_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_uram_row_arbiter
// Brief    : Self-checking bench for uram_row_arbiter (vectors, sequences, random).
// Revision : 1.0
// =============================================================================
module tb_uram_row_arbiter;

    localparam int NC   = 4;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int TO   = 64;
    localparam int WMAX = 1 << AW;

    typedef logic [127:0] w_t;

    typedef struct {
        logic [NC-1:0] req;
        logic [NC-1:0] exp_grant;
        logic [1:0]    exp_owner;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NC-1:0]         core_req, core_locked, core_en, core_we, grant;
    logic [NC-1:0][AW-1:0] core_addr;
    logic [NC-1:0][DW-1:0] core_data;
    logic                  uram_en, uram_we, drain, emptied, busy;
    logic [AW-1:0]         uram_addr;
    logic [DW-1:0]         uram_data;
    logic [AW:0]           wr_count;
    logic [1:0]            owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uram_row_arbiter #(
        .NUM_CORES    (NC),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_core_req          (core_req),
        .i_core_locked       (core_locked),
        .o_core_grant        (grant),
        .i_core_uram_en      (core_en),
        .i_core_uram_wr_en   (core_we),
        .i_core_uram_addr    (core_addr),
        .i_core_uram_wr_data (core_data),
        .o_uram_en           (uram_en),
        .o_uram_wr_en        (uram_we),
        .o_uram_addr         (uram_addr),
        .o_uram_wr_data      (uram_data),
        .i_drain_done        (drain),
        .o_uram_emptied      (emptied),
        .o_wr_count          (wr_count),
        .o_owner             (owner),
        .o_busy              (busy)
    );

    task automatic chk(input string name, input w_t act, input w_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_req    = '0;
        core_locked = '0;
        core_en     = '0;
        core_we     = '0;
        core_addr   = '0;
        core_data   = '0;
        drain       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int t;
        t = 0;
        while (grant == '0 && t < 20) begin
            step(1);
            t++;
        end
        if (grant == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no grant within 20 cycles, got 0x0, expected nonzero", name);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_phase;   // 0 idle, 1 awaiting lock, 2 owned, 3 leaving
    logic [1:0]    m_owner, m_ptr;
    bit            m_empty, m_pend, m_prev, m_gon, m_en, m_we;
    int            m_count, m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    function automatic int rr_pick(input logic [NC-1:0] req, input logic [1:0] start);
        int         r;
        logic [1:0] p;
        r = -1;
        for (int i = NC - 1; i >= 0; i--) begin
            p = start + 2'(i);
            if (req[p]) r = int'(p);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_empty = 1; m_pend = 0; m_prev = 0;
        m_gon = 0; m_en = 0; m_we = 0; m_count = 0; m_age = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_clear_port();
        m_en = 0; m_we = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_step();
        bit lk;
        int nxt;
        lk = core_locked[m_owner];
        case (m_phase)
            0: begin
                m_gon = 0;
                m_age = 0;
                nxt   = rr_pick(core_req, m_ptr);
                if (m_empty && nxt >= 0) begin
                    m_owner = 2'(nxt);
                    m_phase = 1;
                end
                if (drain) begin m_empty = 1; m_count = 0; m_pend = 0; end
            end
            1: begin
                if (drain) m_pend = 1;
                if (lk) begin m_phase = 2; m_gon = 1; end
                else if (m_age == TO) begin m_gon = 0; m_phase = 3; end
                else begin m_gon = 1; m_age++; end
            end
            2: begin
                m_en   = core_en[m_owner];
                m_we   = core_we[m_owner];
                m_addr = core_addr[m_owner];
                m_data = core_data[m_owner];
                if (m_en && m_we) begin
                    m_empty = 0;
                    if (m_count < WMAX) m_count++;
                end
                if (drain) m_pend = 1;
                if (m_prev && !lk) m_phase = 3;
            end
            default: begin
                m_gon = 0;
                model_clear_port();
                m_ptr   = m_owner + 2'd1;
                m_phase = 0;
                if (m_pend || drain) begin m_empty = 1; m_count = 0; m_pend = 0; end
            end
        endcase
        m_prev = lk;
    endtask

    vec_t            vecs[6];
    logic [1:0]      order[5];
    logic [1:0]      e;
    int              cnt;
    w_t              act_v, exp_v;
    logic [NC-1:0]   m_grant;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0100, 4'b0100, 2'd2};
        vecs[1] = '{4'b1111, 4'b0001, 2'd0};
        vecs[2] = '{4'b1010, 4'b0010, 2'd1};
        vecs[3] = '{4'b1000, 4'b1000, 2'd3};
        vecs[4] = '{4'b1100, 4'b0100, 2'd2};
        vecs[5] = '{4'b0011, 4'b0001, 2'd0};
        order   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset values
        clear_inputs();
        reset = 1'b1;
        step(3);
        chk("rst_grant",   w_t'(grant),     w_t'(0));
        chk("rst_uram_en", w_t'(uram_en),   w_t'(0));
        chk("rst_uram_we", w_t'(uram_we),   w_t'(0));
        chk("rst_addr",    w_t'(uram_addr), w_t'(0));
        chk("rst_data",    w_t'(uram_data), w_t'(0));
        chk("rst_emptied", w_t'(emptied),   w_t'(1));
        chk("rst_count",   w_t'(wr_count),  w_t'(0));
        chk("rst_owner",   w_t'(owner),     w_t'(0));
        chk("rst_busy",    w_t'(busy),      w_t'(0));
        reset = 1'b0;

        // Core 2 request, then 16 writes and saturation
        core_req = 4'b0100;
        step(1);
        chk("s1_owner",      w_t'(owner), w_t'(2));
        chk("s1_busy",       w_t'(busy),  w_t'(1));
        chk("s1_grant_lat",  w_t'(grant), w_t'(0));
        step(1);
        chk("s1_grant",      w_t'(grant),   w_t'(4'b0100));
        chk("s1_emptied",    w_t'(emptied), w_t'(1));
        core_locked[2] = 1'b1;
        step(1);
        for (int i = 0; i < 16; i++) begin
            core_en = 4'b0101; core_we = 4'b0101;
            core_addr[2] = AW'(i * 8); core_data[2] = DW'(i);
            core_addr[0] = '1;         core_data[0] = '1;
            step(1);
            chk("wr_addr",    w_t'(uram_addr), w_t'(i * 8));
            chk("wr_data",    w_t'(uram_data), w_t'(i));
            chk("wr_en",      w_t'({uram_en, uram_we}), w_t'(2'b11));
            chk("wr_count",   w_t'(wr_count), w_t'(i + 1));
            chk("wr_emptied", w_t'(emptied),  w_t'(0));
        end
        step(4090);
        chk("wr_saturate", w_t'(wr_count), w_t'(WMAX));
        core_en = '0; core_we = '0; core_locked[2] = 1'b0;
        step(1);
        chk("fall_grant_held", w_t'(grant), w_t'(4'b0100));
        step(1);
        chk("rel_grant",   w_t'(grant),   w_t'(0));
        chk("rel_uram_en", w_t'(uram_en), w_t'(0));

        // Table-driven first pick after reset (pointer 0)
        foreach (vecs[k]) begin
            do_reset();
            core_req = vecs[k].req;
            step(1);
            chk("tbl_owner", w_t'(owner), w_t'(vecs[k].exp_owner));
            step(1);
            chk("tbl_grant", w_t'(grant), w_t'(vecs[k].exp_grant));
        end

        // Round-robin with drains between ownerships
        do_reset();
        core_req = 4'b1111;
        foreach (order[k]) begin
            e = order[k];
            wait_grant("rr_wait");
            chk("rr_grant", w_t'(grant), w_t'(4'b0001 << e));
            chk("rr_owner", w_t'(owner), w_t'(e));
            core_locked[e] = 1'b1;
            step(1);
            core_en[e] = 1'b1; core_we[e] = 1'b1; core_addr[e] = AW'(k);
            step(1);
            core_en = '0; core_we = '0; core_locked[e] = 1'b0;
            step(1);
            chk("rr_held", w_t'(grant), w_t'(4'b0001 << e));
            step(1);
            chk("rr_released", w_t'(grant), w_t'(0));
            step(2);
            chk("rr_blocked",   w_t'(grant),   w_t'(0));
            chk("rr_not_empty", w_t'(emptied), w_t'(0));
            drain = 1'b1;
            step(1);
            drain = 1'b0;
            chk("rr_drained", w_t'(emptied), w_t'(1));
        end

        // Lock timeout revokes grant and advances pointer
        do_reset();
        core_req = 4'b1001;
        step(2);
        chk("to_grant", w_t'(grant), w_t'(4'b0001));
        cnt = 1;
        for (int t = 0; t < 100; t++) begin
            step(1);
            if (grant != 4'b0001) break;
            cnt++;
        end
        chk("to_cycles",  w_t'(cnt),   w_t'(TO));
        chk("to_revoked", w_t'(grant), w_t'(0));
        wait_grant("to_wait");
        chk("to_next_grant", w_t'(grant), w_t'(4'b1000));
        chk("to_next_owner", w_t'(owner), w_t'(3));

        // Drain mid-OWNED is deferred until return to IDLE
        do_reset();
        core_req = 4'b0010;
        wait_grant("dm_wait");
        core_req = '0; core_locked[1] = 1'b1;
        step(1);
        core_en[1] = 1'b1; core_we[1] = 1'b1;
        step(1);
        core_en = '0; core_we = '0;
        chk("dm_empty0", w_t'(emptied),  w_t'(0));
        chk("dm_count1", w_t'(wr_count), w_t'(1));
        drain = 1'b1;
        step(1);
        drain = 1'b0;
        chk("dm_hold_empty", w_t'(emptied),  w_t'(0));
        chk("dm_hold_count", w_t'(wr_count), w_t'(1));
        step(2);
        core_locked[1] = 1'b0;
        step(1);
        chk("dm_fall_empty", w_t'(emptied), w_t'(0));
        step(1);
        chk("dm_applied_empty", w_t'(emptied),  w_t'(1));
        chk("dm_applied_count", w_t'(wr_count), w_t'(0));
        chk("dm_idle",          w_t'(busy),     w_t'(0));

        // Reset during OWNED writes
        do_reset();
        core_req = 4'b0100;
        wait_grant("rm_wait");
        core_locked[2] = 1'b1;
        step(1);
        core_en[2] = 1'b1; core_we[2] = 1'b1; core_addr[2] = 12'd5;
        step(3);
        chk("rm_pre_en", w_t'(uram_en), w_t'(1));
        reset = 1'b1;
        step(1);
        chk("rm_grant",   w_t'(grant),    w_t'(0));
        chk("rm_uram_en", w_t'(uram_en),  w_t'(0));
        chk("rm_emptied", w_t'(emptied),  w_t'(1));
        chk("rm_count",   w_t'(wr_count), w_t'(0));
        chk("rm_busy",    w_t'(busy),     w_t'(0));
        clear_inputs();
        reset = 1'b0;
        core_req = 4'b1111;
        step(1);
        chk("rm_ptr_owner", w_t'(owner), w_t'(0));
        step(1);
        chk("rm_ptr_grant", w_t'(grant), w_t'(4'b0001));

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            core_req    = NC'($urandom);
            core_locked = core_locked ^ NC'($urandom & $urandom & $urandom);
            core_en     = NC'($urandom);
            core_we     = NC'($urandom);
            for (int k = 0; k < NC; k++) begin
                core_addr[k] = AW'($urandom);
                core_data[k] = DW'($urandom);
            end
            drain = ($urandom_range(9) == 0);
            @(posedge clk);
            model_step();
            #1;
            m_grant = m_gon ? (4'b0001 << m_owner) : 4'b0000;
            exp_v = w_t'({m_grant, m_owner, m_empty, 13'(m_count), (m_phase != 0),
                          m_en, m_we, m_addr, m_data});
            act_v = w_t'({grant, owner, emptied, wr_count, busy,
                          uram_en, uram_we, uram_addr, uram_data});
            chk("rand_cycle", act_v, exp_v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
